// File: rtl/spi_peripheral_pkg.sv
// Shared SPI peripheral types: FSM state encoding, frame size limit and the
// helper that masks a received word down to its captured length.
package spi_peripheral_pkg;

  localparam int SPI_PERIPH_MAX_BITS = 24;
  localparam int SPI_PERIPH_DATA_W   = 24;

  typedef logic [1:0] spi_periph_state_t;

  localparam spi_periph_state_t S_IDLE   = 2'd0;
  localparam spi_periph_state_t S_ACTIVE = 2'd1;
  localparam spi_periph_state_t S_DONE   = 2'd2;

  // Keep only the low n bits; n at or above the data width keeps everything.
  function automatic logic [SPI_PERIPH_DATA_W-1:0] len_mask(input logic [4:0] n);
    if (n >= 5'(SPI_PERIPH_DATA_W))
      return '1;
    else
      return (SPI_PERIPH_DATA_W'(1) << n) - SPI_PERIPH_DATA_W'(1);
  endfunction

endpackage

// File: rtl/spi_peripheral_synchronizer.sv
// Multi-flop synchronizer for one asynchronous input, with a selectable
// reset value so inactive-high lines come out of reset deasserted.
module spi_synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sync_q <= {STAGES{RESET_VAL}};
    else
      sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// Mode-0 SPI peripheral oversampled by clk: shifts a preloaded response out on
// miso while capturing mosi, then hands the received word over a valid/ready port.
//
// state    | meaning
// S_IDLE   | waiting for csb to fall while armed
// S_ACTIVE | frame in progress, miso driven, sclk edges shift data
// S_DONE   | one-cycle frame wrap-up: deliver, drop or discard the word
module spi_peripheral
  import spi_peripheral_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_BITS    = SPI_PERIPH_MAX_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         csb,
  input  logic                         mosi,
  output logic                         miso,
  output logic                         miso_oe,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic [SPI_PERIPH_DATA_W-1:0] i_data,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [SPI_PERIPH_DATA_W-1:0] o_data,
  output logic [4:0]                   o_bit_count,
  output logic                         o_error
);

  localparam logic [4:0] MAX_CNT = 5'(MAX_BITS);

  logic sclk_s, csb_s, mosi_s;
  logic sclk_d, csb_d;
  logic sclk_rise, sclk_fall, csb_fall, csb_rise;
  logic [1:0] warm_cnt;
  logic armed;
  logic accept, frame_start;
  logic tx_full, overrun;
  logic [SPI_PERIPH_DATA_W-1:0] tx_hold, tx_shift, rx_shift;
  logic [4:0] bit_count;
  spi_periph_state_t state;

  spi_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
  );

  spi_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csb (
    .clk(clk), .rst(rst), .d(csb), .q(csb_s)
  );

  spi_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
  );

  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign csb_fall    = ~csb_s & csb_d;
  assign csb_rise    = csb_s & ~csb_d;

  assign i_ready     = ~tx_full;
  assign accept      = i_valid & i_ready;
  assign frame_start = (state == S_IDLE) & armed & csb_fall;

  assign miso        = tx_shift[SPI_PERIPH_DATA_W-1];
  assign miso_oe     = (state == S_ACTIVE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      sclk_d      <= 1'b0;
      csb_d       <= 1'b1;
      warm_cnt    <= 2'(SYNC_STAGES);
      armed       <= 1'b0;
      tx_full     <= 1'b0;
      tx_hold     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_count   <= '0;
      overrun     <= 1'b0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_bit_count <= '0;
      o_error     <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      csb_d  <= csb_s;

      // The csb synchronizer holds its reset value until flushed; only trust
      // csb_s for arming once the pin has propagated through every stage.
      if (warm_cnt != 2'd0)
        warm_cnt <= warm_cnt - 2'd1;
      else if (csb_s)
        armed <= 1'b1;

      if (frame_start)
        tx_full <= 1'b0;
      else if (accept) begin
        tx_hold <= i_data;
        tx_full <= 1'b1;
      end

      if (o_valid && o_ready)
        o_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state     <= S_ACTIVE;
            tx_shift  <= accept ? i_data : (tx_full ? tx_hold : '0);
            bit_count <= '0;
            overrun   <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (csb_rise)
            state <= S_DONE;
          if (sclk_rise) begin
            rx_shift <= {rx_shift[SPI_PERIPH_DATA_W-2:0], mosi_s};
            if (bit_count == MAX_CNT)
              overrun <= 1'b1;
            else
              bit_count <= bit_count + 5'd1;
          end
          if (sclk_fall)
            tx_shift <= {tx_shift[SPI_PERIPH_DATA_W-2:0], 1'b0};
        end
        S_DONE: begin
          state <= S_IDLE;
          if (bit_count != 5'd0) begin
            if (o_valid && !o_ready)
              o_error <= 1'b1;
            else begin
              o_data      <= rx_shift & len_mask(bit_count);
              o_bit_count <= bit_count;
              o_valid     <= 1'b1;
              if (overrun)
                o_error <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed self-checking bench for spi_peripheral: drives mode-0 frames with a
// slow sclk and checks miso streams, delivered words, latency and error flag.
module tb_spi_peripheral;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk, csb, mosi;
  logic        miso, miso_oe;
  logic        i_valid, i_ready;
  logic [23:0] i_data;
  logic        o_valid, o_ready;
  logic [23:0] o_data;
  logic [4:0]  o_bit_count;
  logic        o_error;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mb;
  logic        oe_all;
  int          seen;

  always #5 clk = ~clk;

  spi_peripheral #(.SYNC_STAGES(2), .MAX_BITS(24)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .csb(csb), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_bit_count(o_bit_count), .o_error(o_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clock_bits(input logic [31:0] bits, input int n,
                            output logic [31:0] mbits, output logic oe);
    mbits = '0;
    oe    = 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      repeat (6) @(negedge clk);
      mbits = {mbits[30:0], miso};
      oe    = oe & miso_oe;
      sclk  = 1'b1;
      repeat (6) @(negedge clk);
      sclk  = 1'b0;
    end
  endtask

  // byp: present word on i_valid in the exact cycle the csb fall is detected
  task automatic send_frame(input logic [31:0] bits, input int n, input logic byp,
                            input logic [23:0] word,
                            output logic [31:0] mbits, output logic oe);
    csb = 1'b0;
    if (byp) begin
      repeat (2) @(negedge clk);
      i_valid = 1'b1;
      i_data  = word;
      @(negedge clk);
      i_valid = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    clock_bits(bits, n, mbits, oe);
    repeat (6) @(negedge clk);
    csb = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, "_early"}, 32'(o_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_lat"}, 32'(o_valid), 32'd1);
  endtask

  task automatic ack(input string tag);
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    chk({tag, "_ack"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b0; sclk = 1'b0; csb = 1'b1; mosi = 1'b0;
    i_valid = 1'b0; i_data = '0; o_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_o_bit_count", 32'(o_bit_count), 32'd0);
    chk("rst_o_error", 32'(o_error), 32'd0);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_miso_oe", 32'(miso_oe), 32'd0);
    chk("rst_i_ready", 32'(i_ready), 32'd1);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Preloaded response, 16-bit frame
    i_valid = 1'b1; i_data = 24'hA5C300;
    @(negedge clk);
    i_valid = 1'b0;
    chk("load_i_ready", 32'(i_ready), 32'd0);
    send_frame(32'h1234, 16, 1'b0, 24'h0, mb, oe_all);
    chk("f16_miso", mb, 32'hA5C3);
    chk("f16_oe", 32'(oe_all), 32'd1);
    wait_valid("f16");
    chk("f16_data", 32'(o_data), 32'h001234);
    chk("f16_count", 32'(o_bit_count), 32'd16);
    chk("f16_error", 32'(o_error), 32'd0);
    chk("f16_i_ready", 32'(i_ready), 32'd1);
    ack("f16");
    repeat (4) @(negedge clk);

    // No preload, 8-bit all-ones
    send_frame(32'hFF, 8, 1'b0, 24'h0, mb, oe_all);
    chk("f8_miso", mb, 32'h0);
    wait_valid("f8");
    chk("f8_data", 32'(o_data), 32'h0000FF);
    chk("f8_count", 32'(o_bit_count), 32'd8);
    ack("f8");
    repeat (4) @(negedge clk);

    // Accept coinciding with frame start bypasses the holding register
    send_frame(32'h3C, 8, 1'b1, 24'h5A0000, mb, oe_all);
    chk("byp_miso", mb, 32'h5A);
    chk("byp_i_ready", 32'(i_ready), 32'd1);
    wait_valid("byp");
    chk("byp_data", 32'(o_data), 32'h00003C);
    chk("byp_count", 32'(o_bit_count), 32'd8);
    chk("byp_i_ready_after", 32'(i_ready), 32'd1);
    ack("byp");
    repeat (4) @(negedge clk);

    // Back-pressure: second word dropped
    send_frame(32'h11, 8, 1'b0, 24'h0, mb, oe_all);
    wait_valid("bp1");
    chk("bp1_data", 32'(o_data), 32'h11);
    chk("bp1_error", 32'(o_error), 32'd0);
    repeat (4) @(negedge clk);
    send_frame(32'h22, 8, 1'b0, 24'h0, mb, oe_all);
    repeat (8) @(negedge clk);
    chk("bp2_valid", 32'(o_valid), 32'd1);
    chk("bp2_data", 32'(o_data), 32'h11);
    chk("bp2_error", 32'(o_error), 32'd1);
    ack("bp");
    repeat (4) @(negedge clk);

    // Reset mid-frame, released with csb still low
    csb = 1'b0;
    repeat (6) @(negedge clk);
    clock_bits(32'h15, 5, mb, oe_all);
    chk("mid_oe_before", 32'(miso_oe), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_oe_reset", 32'(miso_oe), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    clock_bits(32'h5, 3, mb, oe_all);
    repeat (6) @(negedge clk);
    csb = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    chk("mid_no_valid", 32'(seen), 32'd0);
    chk("mid_error_cleared", 32'(o_error), 32'd0);
    send_frame(32'hC3, 8, 1'b0, 24'h0, mb, oe_all);
    wait_valid("post");
    chk("post_data", 32'(o_data), 32'hC3);
    chk("post_count", 32'(o_bit_count), 32'd8);
    ack("post");
    repeat (4) @(negedge clk);

    // 26-bit overrun keeps the last 24 bits
    send_frame(32'h3ABCDEF, 26, 1'b0, 24'h0, mb, oe_all);
    wait_valid("ovr");
    chk("ovr_count", 32'(o_bit_count), 32'd24);
    chk("ovr_data", 32'(o_data), 32'hABCDEF);
    chk("ovr_error", 32'(o_error), 32'd1);
    ack("ovr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
